// File: rtl/mod_clock_enable_gen.sv
// Fractional clock-enable generator: per-channel phase accumulators producing
// single-cycle strobes, plus a lock-qualified system reset sequencer.
module mod_clock_enable_gen #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 24,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = '0,
  parameter int RST_HOLD = 1024,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_pll_locked,
  input  logic [NUM_CH-1:0] in_ch_en,
  input  logic              in_wr_en,
  input  logic [CH_W-1:0]   in_wr_ch,
  input  logic [ACC_W-1:0]  in_wr_inc,
  output logic [NUM_CH-1:0] out_ce,
  output logic [NUM_CH-1:0] out_phase,
  output logic              out_locked,
  output logic              out_rst_n
);

  localparam int CNT_W = $clog2(RST_HOLD + 1);

  typedef enum logic {
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lock_meta, lock_sync;
  logic [ACC_W-1:0]   inc_q [NUM_CH];
  logic [ACC_W-1:0]   acc_q [NUM_CH];
  logic [NUM_CH-1:0]  ce_q;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= in_pll_locked;
      lock_sync <= lock_meta;
    end
  end

  assign out_locked = lock_sync;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle of lost lock restarts the hold count from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (!lock_sync) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          state_d = ST_RUN;
        end else if (cnt_q != CNT_W'(RST_HOLD)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_sync) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  assign out_rst_n = (state_q == ST_RUN);

  // Out-of-range channel indices match no register and are dropped.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
      end
    end else if (in_wr_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_wr_ch == CH_W'(i)) begin
          inc_q[i] <= in_wr_inc;
        end
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
      ce_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!out_rst_n || !in_ch_en[i]) begin
          acc_q[i] <= '0;
          ce_q[i]  <= 1'b0;
        end else begin
          {ce_q[i], acc_q[i]} <= {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
        end
      end
    end
  end

  assign out_ce = ce_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_phase
    assign out_phase[g] = acc_q[g][ACC_W-1];
  end

endmodule

// File: tb/tb_mod_clock_enable_gen.sv
// Scoreboard bench for mod_clock_enable_gen: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_mod_clock_enable_gen;

  localparam int NUM_CH = 3;
  localparam int ACC_W = 24;
  localparam int RST_HOLD = 8;
  localparam logic [NUM_CH*ACC_W-1:0] INC_INIT = {24'h123456, 24'h400000, 24'h400000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pll;
  logic [2:0]  ch_en;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [23:0] wr_inc;
  logic [2:0]  ce;
  logic [2:0]  phase;
  logic        locked;
  logic        sys_rst_n;

  mod_clock_enable_gen #(
    .NUM_CH(NUM_CH),
    .ACC_W(ACC_W),
    .INC_INIT(INC_INIT),
    .RST_HOLD(RST_HOLD)
  ) dut (
    .in_clk(clk),
    .in_rst_n(rst_n),
    .in_pll_locked(pll),
    .in_ch_en(ch_en),
    .in_wr_en(wr_en),
    .in_wr_ch(wr_ch),
    .in_wr_inc(wr_inc),
    .out_ce(ce),
    .out_phase(phase),
    .out_locked(locked),
    .out_rst_n(sys_rst_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 ce bit, 1 phase bit, 2 locked, 3 system reset, 4 strobe count, 5 gap spread
  typedef struct {
    int    cyc;
    string name;
    int    kind;
    int    ch;
    int    val;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  int strobe_cnt = 0;
  int last_strobe = -1;
  int min_gap = 1000000;
  int max_gap = 0;
  int win_lo = -1;
  int win_hi = -2;

  task automatic expectAt(input int d, input string name, input int kind, input int ch, input int val);
    exp_t e;
    e.cyc  = cyc + d;
    e.name = name;
    e.kind = kind;
    e.ch   = ch;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic p, input logic [2:0] en,
                               input logic w, input logic [1:0] wc, input logic [23:0] wi);
    rst_n  = r;
    pll    = p;
    ch_en  = en;
    wr_en  = w;
    wr_ch  = wc;
    wr_inc = wi;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic int actualOf(input int kind, input int ch);
    case (kind)
      0: return int'(ce[ch]);
      1: return int'(phase[ch]);
      2: return int'(locked);
      3: return int'(sys_rst_n);
      4: return strobe_cnt;
      default: return max_gap - min_gap;
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    int act;
    act = actualOf(e.kind, e.ch);
    tests++;
    if (act != e.val) begin
      fails++;
      $display("[TB] FAIL %s ch%0d @cyc %0d: got %0d, expected %0d", e.name, e.ch, e.cyc, act, e.val);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        tests++;
        fails++;
        $display("[TB] FAIL %s missed @cyc %0d: got none, expected %0d", sb[i].name, sb[i].cyc, sb[i].val);
        sb.delete(i);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= win_lo && cyc <= win_hi && ce[2]) begin
      if (last_strobe >= 0) begin
        if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
        if (cyc - last_strobe > max_gap) max_gap = cyc - last_strobe;
      end
      last_strobe = cyc;
      strobe_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state, with lock and enables already asserted
    applyStimulus(1'b0, 1'b1, 3'b111, 1'b0, 2'd0, 24'h0);
    step(3);
    for (int c = 0; c < NUM_CH; c++) begin
      expectAt(1, "reset_ce", 0, c, 0);
      expectAt(1, "reset_phase", 1, c, 0);
    end
    expectAt(1, "reset_locked", 2, 0, 0);
    expectAt(1, "reset_rst_n", 3, 0, 0);
    step(2);
    applyStimulus(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 24'h0);
    step(2);

    // Reset sequencing: lock at 0 -> locked at 2, release at 10
    applyStimulus(1'b1, 1'b1, 3'b111, 1'b0, 2'd0, 24'h0);
    expectAt(1, "seq_locked", 2, 0, 0);
    expectAt(2, "seq_locked", 2, 0, 1);
    expectAt(5, "hold_ce", 0, 0, 0);
    expectAt(6, "hold_ce", 0, 2, 0);
    expectAt(9, "seq_rst_n", 3, 0, 0);
    expectAt(10, "seq_rst_n", 3, 0, 1);
    step(9);
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 2'd0, 24'h0);
    step(1);

    // Integer divide by 4 on channel 0
    applyStimulus(1'b1, 1'b1, 3'b001, 1'b0, 2'd0, 24'h0);
    expectAt(3, "div4_ce", 0, 0, 0);
    expectAt(4, "div4_ce", 0, 0, 1);
    expectAt(5, "div4_ce", 0, 0, 0);
    expectAt(8, "div4_ce", 0, 0, 1);
    expectAt(12, "div4_ce", 0, 0, 1);
    expectAt(4, "disabled_ce", 0, 1, 0);
    expectAt(1, "div4_phase", 1, 0, 0);
    expectAt(2, "div4_phase", 1, 0, 1);
    expectAt(3, "div4_phase", 1, 0, 1);
    expectAt(4, "div4_phase", 1, 0, 0);
    expectAt(6, "div4_phase", 1, 0, 1);
    step(12);

    // Runtime write of channel 1 from 0x400000 to 0x800000, then an out-of-range write
    applyStimulus(1'b1, 1'b1, 3'b011, 1'b0, 2'd0, 24'h0);
    expectAt(4, "wr_ce", 0, 1, 1);
    expectAt(5, "wr_ce", 0, 1, 0);
    expectAt(6, "wr_ce", 0, 1, 0);
    expectAt(7, "wr_ce", 0, 1, 1);
    expectAt(8, "wr_ce", 0, 1, 0);
    expectAt(9, "wr_ce", 0, 1, 1);
    expectAt(10, "wr_ce", 0, 1, 0);
    expectAt(11, "wr_ce", 0, 1, 1);
    expectAt(13, "badwr_ce", 0, 1, 1);
    expectAt(15, "badwr_ce", 0, 1, 1);
    expectAt(16, "badwr_ce", 0, 1, 0);
    expectAt(14, "badwr_ce", 0, 0, 0);
    expectAt(16, "badwr_ce", 0, 0, 1);
    expectAt(10, "badwr_ce", 0, 2, 0);
    step(5);
    applyStimulus(1'b1, 1'b1, 3'b011, 1'b1, 2'd1, 24'h800000);
    step(1);
    applyStimulus(1'b1, 1'b1, 3'b011, 1'b0, 2'd0, 24'h0);
    step(5);
    applyStimulus(1'b1, 1'b1, 3'b011, 1'b1, 2'd3, 24'h000000);
    step(1);
    applyStimulus(1'b1, 1'b1, 3'b011, 1'b0, 2'd0, 24'h0);
    step(6);

    // Lock loss in RUN
    applyStimulus(1'b1, 1'b0, 3'b011, 1'b0, 2'd0, 24'h0);
    expectAt(1, "loss_locked", 2, 0, 1);
    expectAt(2, "loss_locked", 2, 0, 0);
    expectAt(2, "loss_rst_n", 3, 0, 1);
    expectAt(3, "loss_rst_n", 3, 0, 0);
    expectAt(3, "loss_ce", 0, 1, 1);
    expectAt(4, "loss_ce", 0, 0, 0);
    expectAt(4, "loss_phase", 1, 0, 0);
    expectAt(4, "loss_phase", 1, 1, 0);
    expectAt(5, "loss_ce", 0, 1, 0);
    expectAt(5, "loss_phase", 1, 0, 0);
    step(6);

    // Write during HOLD, then async reset must restore INC_INIT
    applyStimulus(1'b1, 1'b0, 3'b011, 1'b1, 2'd0, 24'h800000);
    step(1);
    applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, 2'd0, 24'h0);
    expectAt(1, "async_rst_n", 3, 0, 0);
    step(2);
    applyStimulus(1'b1, 1'b0, 3'b001, 1'b0, 2'd0, 24'h0);
    step(2);

    // Lock glitch during the hold count
    applyStimulus(1'b1, 1'b1, 3'b001, 1'b0, 2'd0, 24'h0);
    expectAt(2, "glitch_locked", 2, 0, 1);
    expectAt(7, "glitch_locked", 2, 0, 0);
    expectAt(8, "glitch_locked", 2, 0, 1);
    expectAt(10, "glitch_rst_n", 3, 0, 0);
    expectAt(15, "glitch_rst_n", 3, 0, 0);
    expectAt(16, "glitch_rst_n", 3, 0, 1);
    expectAt(12, "glitch_ce", 0, 0, 0);
    expectAt(18, "restored_inc_ce", 0, 0, 0);
    expectAt(19, "restored_inc_ce", 0, 0, 0);
    expectAt(20, "restored_inc_ce", 0, 0, 1);
    expectAt(24, "restored_inc_ce", 0, 0, 1);
    step(5);
    applyStimulus(1'b1, 1'b0, 3'b001, 1'b0, 2'd0, 24'h0);
    step(1);
    applyStimulus(1'b1, 1'b1, 3'b001, 1'b0, 2'd0, 24'h0);
    step(19);

    // Fractional rate: 4096 adds of 0x123456 give floor(0x123456/4096) = 291 strobes
    applyStimulus(1'b1, 1'b1, 3'b100, 1'b0, 2'd0, 24'h0);
    win_lo = cyc + 1;
    win_hi = cyc + 4096;
    expectAt(4097, "frac_count", 4, 2, 291);
    expectAt(4097, "frac_gap_spread", 5, 2, 1);
    step(4100);

    step(3);
    while (sb.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s unchecked @cyc %0d: got none, expected %0d", sb[0].name, sb[0].cyc, sb[0].val);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
